vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing generator for the VGA pipeline; sits directly upstream of the overlay/shape-drawing stages (frame border, sprites).
- Divides the system clock down to a pixel tick.
- Produces 10-bit pixel coordinates counter_x/counter_y, hsync/vsync, video_on and line/frame start strobes, all registered and mutually aligned.
- Default timing is 640x480@60 (800x525 total) from a 100 MHz clk with divide-by-4.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, horizontal sync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 4, clk cycles per pixel tick; legal range 1..16
- SYNC_POL, 0, active level of hsync/vsync; 0 = active-low

Ports:
- clk  input  1  system clock
- rst  input  1  reset; one clock; asynchronous, active-high
- counter_x  output  10  current pixel column, 0..H_TOTAL-1
- counter_y  output  10  current line, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, level per SYNC_POL
- vsync  output  1  vertical sync, level per SYNC_POL
- video_on  output  1  high when counter_x<H_ACTIVE and counter_y<V_ACTIVE
- pixel_tick  output  1  one-clk strobe; coordinates changed on this cycle
- line_start  output  1  one-clk strobe coincident with pixel_tick when counter_x becomes 0
- frame_start  output  1  one-clk strobe coincident with pixel_tick when counters become (0,0)

Behaviour:
- Totals and constraints:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
  - Both totals must be ≤1024.
- Reset (async, immediate, no clock needed):
  - div_cnt=0, counter_x=H_TOTAL-1, counter_y=V_TOTAL-1.
  - video_on=0; hsync=vsync=~SYNC_POL (inactive); all strobes 0.
  - These values are self-consistent: (799,524) is blanked and outside both sync windows.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - Advance occurs on the clk edge where div_cnt==CLK_DIV-1.
  - CLK_DIV=1 advances every edge.
- On each advance edge, with next coordinates nx/ny, the following are registered together so all outputs describe the same pixel:
  - counter_x <= nx, counter_y <= ny.
  - hsync <= SYNC_POL when H_ACTIVE+H_FP ≤ nx < H_ACTIVE+H_FP+H_SYNC (656..751), else ~SYNC_POL.
  - vsync <= SYNC_POL when V_ACTIVE+V_FP ≤ ny < V_ACTIVE+V_FP+V_SYNC (490..491), else ~SYNC_POL.
  - video_on <= (nx<H_ACTIVE)&&(ny<V_ACTIVE).
  - pixel_tick <= 1.
  - line_start <= (nx==0); frame_start <= (nx==0 && ny==0).
- Coordinate wrap:
  - x wrap: counter_x==H_TOTAL-1 → nx=0, ny=counter_y+1.
  - y wrap: both at max → nx=0, ny=0.
  - Otherwise nx=counter_x+1, ny=counter_y.
- Non-advance edges: all strobes 0; coordinates, syncs and video_on hold.
- Latency and timing:
  - First advance occurs CLK_DIV clk edges after rst deasserts.
  - That advance yields (0,0), video_on=1, line_start=frame_start=1.
  - Frame period = H_TOTAL*V_TOTAL*CLK_DIV clks (1,680,000 default).
- Reset asserted mid-frame returns immediately to the reset values above; no partial-line state survives.
- Downstream stages may sample coordinates every clk; values are stable for CLK_DIV clks between advances.

Test Plan:
- Reset release: rst 1→0, CLK_DIV=4 → 4th edge gives counter_x=0, counter_y=0, video_on=1, pixel_tick=line_start=frame_start=1; hsync=vsync=1.
- Active edge: run to counter_y=0 → video_on=1 at x=639, 0 at x=640; hsync low exactly for x=656..751 (96 ticks = 384 clks); video_on=0 throughout hsync.
- Line wrap: x=799,y=5 → next advance x=0,y=6, line_start=1, frame_start=0; pixel_tick high 1 of every 4 clks.
- Vertical: vsync low for y=490..491 only (1600 ticks); (799,524) → (0,0) with frame_start; exactly one frame_start per 1,680,000 clks.
- Override CLK_DIV=1 → pixel_tick high every clk; line period = 800 clks; frame_start period = 420,000 clks.
- Async reset: assert rst at x=300,y=200 between clk edges → outputs return to (799,524), video_on=0, syncs inactive with no clk edge; restart as in the reset-release scenario.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - raster timing generator: pixel-tick divider, x/y counters, syncs and strobes
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] counter_x,
    output logic [9:0] counter_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

    localparam logic [9:0] H_MAX   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX   = 10'(V_TOTAL - 1);
    localparam logic [3:0] DIV_MAX = 4'(CLK_DIV - 1);
    localparam logic       SYNC_ON = (SYNC_POL != 0);

    logic [3:0] div_cnt;
    logic       advance;
    logic [9:0] nx;
    logic [9:0] ny;
    logic       h_sync_win;
    logic       v_sync_win;
    logic       active_next;

    assign advance = (div_cnt == DIV_MAX);

    always_comb begin
        nx = counter_x + 10'd1;
        ny = counter_y;
        if (counter_x == H_MAX) begin
            nx = 10'd0;
            ny = (counter_y == V_MAX) ? 10'd0 : counter_y + 10'd1;
        end
    end

    // Decode from the next coordinates so syncs/video_on land on the same edge as the counters.
    // 11-bit compares keep window ends of exactly 1024 representable.
    assign h_sync_win  = ({1'b0, nx} >= 11'(H_SYNC_START)) && ({1'b0, nx} < 11'(H_SYNC_END));
    assign v_sync_win  = ({1'b0, ny} >= 11'(V_SYNC_START)) && ({1'b0, ny} < 11'(V_SYNC_END));
    assign active_next = ({1'b0, nx} < 11'(H_ACTIVE)) && ({1'b0, ny} < 11'(V_ACTIVE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt     <= 4'd0;
            counter_x   <= H_MAX;
            counter_y   <= V_MAX;
            hsync       <= ~SYNC_ON;
            vsync       <= ~SYNC_ON;
            video_on    <= 1'b0;
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            pixel_tick  <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            div_cnt     <= advance ? 4'd0 : div_cnt + 4'd1;
            if (advance) begin
                counter_x   <= nx;
                counter_y   <= ny;
                hsync       <= h_sync_win ? SYNC_ON : ~SYNC_ON;
                vsync       <= v_sync_win ? SYNC_ON : ~SYNC_ON;
                video_on    <= active_next;
                pixel_tick  <= 1'b1;
                line_start  <= (nx == 10'd0);
                frame_start <= (nx == 10'd0) && (ny == 10'd0);
            end
        end
    end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench: 800-wide lines with an 8-line frame, divide-by-4 and divide-by-1 instances
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [9:0] a_x, a_y, b_x, b_y;
    logic a_hs, a_vs, a_von, a_tick, a_ls, a_fs;
    logic b_hs, b_vs, b_von, b_tick, b_ls, b_fs;

    wire [25:0] a_vec = {a_x, a_y, a_von, a_hs, a_vs, a_tick, a_ls, a_fs};
    wire [25:0] b_vec = {b_x, b_y, b_von, b_hs, b_vs, b_tick, b_ls, b_fs};

    // Vertical: 4 active, FP 1, sync lines 5..6, BP 1 -> 8 lines; horizontal is the 640x480 default.
    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(4), .SYNC_POL(0)) dut_a (
        .clk(clk), .rst(rst), .counter_x(a_x), .counter_y(a_y), .hsync(a_hs), .vsync(a_vs),
        .video_on(a_von), .pixel_tick(a_tick), .line_start(a_ls), .frame_start(a_fs));

    vga_timing_gen #(.V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .CLK_DIV(1), .SYNC_POL(1)) dut_b (
        .clk(clk), .rst(rst), .counter_x(b_x), .counter_y(b_y), .hsync(b_hs), .vsync(b_vs),
        .video_on(b_von), .pixel_tick(b_tick), .line_start(b_ls), .frame_start(b_fs));

    always #5 clk = ~clk;

    task automatic wait_a(input logic [9:0] x, input logic [9:0] y, input int limit, input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (a_tick && a_x == x && a_y == y) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: reached (%0d,%0d), expected (%0d,%0d) within %0d clks", tag, a_x, a_y, x, y, limit);
        end
    endtask

    task automatic release_and_check(input string tag);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (a_vec !== {10'd799, 10'd7, 6'b011000}) begin
            n_fail++;
            $display("FAIL %s_a_pre: got %h expected %h", tag, a_vec, {10'd799, 10'd7, 6'b011000});
        end
        n_checks++;
        if (b_vec !== {10'd2, 10'd0, 6'b100100}) begin
            n_fail++;
            $display("FAIL %s_b_pre: got %h expected %h", tag, b_vec, {10'd2, 10'd0, 6'b100100});
        end
        @(negedge clk);
        n_checks++;
        if (a_vec !== {10'd0, 10'd0, 6'b111111}) begin
            n_fail++;
            $display("FAIL %s_a_first: got %h expected %h", tag, a_vec, {10'd0, 10'd0, 6'b111111});
        end
        n_checks++;
        if (b_vec !== {10'd3, 10'd0, 6'b100100}) begin
            n_fail++;
            $display("FAIL %s_b_first: got %h expected %h", tag, b_vec, {10'd3, 10'd0, 6'b100100});
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if (a_vec !== {10'd799, 10'd7, 6'b011000}) begin
            n_fail++;
            $display("FAIL reset_a: got %h expected %h", a_vec, {10'd799, 10'd7, 6'b011000});
        end
        n_checks++;
        if (b_vec !== {10'd799, 10'd7, 6'b000000}) begin
            n_fail++;
            $display("FAIL reset_b: got %h expected %h", b_vec, {10'd799, 10'd7, 6'b000000});
        end
        release_and_check("release");
    endtask

    task automatic test_active_edge();
        int hs_low = 0;
        int bad = 0;
        wait_a(10'd639, 10'd0, 3000, "wait_639");
        n_checks++;
        if (a_von !== 1'b1) begin
            n_fail++;
            $display("FAIL von_639: got %b expected 1", a_von);
        end
        wait_a(10'd640, 10'd0, 8, "wait_640");
        n_checks++;
        if ({a_von, a_hs} !== 2'b01) begin
            n_fail++;
            $display("FAIL von_640: got von/hs %b expected 01", {a_von, a_hs});
        end
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (!a_hs) begin
                hs_low++;
                if (a_von || a_x < 10'd656 || a_x > 10'd751) bad++;
            end else if (a_x >= 10'd656 && a_x <= 10'd751) begin
                bad++;
            end
            if (a_tick && a_x == 10'd799) break;
        end
        n_checks++;
        if (hs_low != 384) begin
            n_fail++;
            $display("FAIL hsync_width: got %0d clks expected 384", hs_low);
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL hsync_window: got %0d bad samples expected 0", bad);
        end
    endtask

    task automatic test_line_wrap();
        int n = 0;
        wait_a(10'd799, 10'd5, 17000, "wait_799_5");
        n_checks++;
        if ({a_von, a_vs} !== 2'b00) begin
            n_fail++;
            $display("FAIL vsync_y5: got von/vs %b expected 00", {a_von, a_vs});
        end
        do begin
            @(negedge clk);
            n++;
        end while (!a_tick && n < 8);
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL tick_period: got %0d clks expected 4", n);
        end
        n_checks++;
        if ({a_x, a_y, a_ls, a_fs, a_von, a_vs} !== {10'd0, 10'd6, 4'b1000}) begin
            n_fail++;
            $display("FAIL line_wrap: got %h expected %h", {a_x, a_y, a_ls, a_fs, a_von, a_vs}, {10'd0, 10'd6, 4'b1000});
        end
    endtask

    task automatic test_vertical();
        bit ok = 1'b0;
        int n = 0, ticks = 0, vs_low = 0, bad = 0, lines = 0;
        logic [9:0] px = '0, py = '0;
        for (int i = 0; i < 8000; i++) begin
            @(negedge clk);
            if (a_fs) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_frame: got no frame_start expected one within 8000 clks");
        end
        for (int i = 0; i < 26000; i++) begin
            @(negedge clk);
            n++;
            if (a_tick) begin
                ticks++;
                if (!a_vs) begin
                    vs_low++;
                    if (a_y != 10'd5 && a_y != 10'd6) bad++;
                end else if (a_y == 10'd5 || a_y == 10'd6) begin
                    bad++;
                end
                if (a_ls) lines++;
                if (a_fs) break;
                px = a_x;
                py = a_y;
            end
        end
        n_checks++;
        if (n != 25600) begin
            n_fail++;
            $display("FAIL frame_period: got %0d clks expected 25600", n);
        end
        n_checks++;
        if (ticks != 6400) begin
            n_fail++;
            $display("FAIL frame_ticks: got %0d expected 6400", ticks);
        end
        n_checks++;
        if (vs_low != 1600 || bad != 0) begin
            n_fail++;
            $display("FAIL vsync_window: got low=%0d bad=%0d expected low=1600 bad=0", vs_low, bad);
        end
        n_checks++;
        if (lines != 8) begin
            n_fail++;
            $display("FAIL line_count: got %0d expected 8", lines);
        end
        n_checks++;
        if ({px, py} !== {10'd799, 10'd7}) begin
            n_fail++;
            $display("FAIL frame_wrap_from: got (%0d,%0d) expected (799,7)", px, py);
        end
    endtask

    task automatic test_async_reset();
        wait_a(10'd300, 10'd2, 9000, "wait_300_2");
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (a_vec !== {10'd799, 10'd7, 6'b011000}) begin
            n_fail++;
            $display("FAIL async_a: got %h expected %h", a_vec, {10'd799, 10'd7, 6'b011000});
        end
        n_checks++;
        if (b_vec !== {10'd799, 10'd7, 6'b000000}) begin
            n_fail++;
            $display("FAIL async_b: got %h expected %h", b_vec, {10'd799, 10'd7, 6'b000000});
        end
        release_and_check("restart");
    endtask

    task automatic test_clkdiv1();
        bit ok = 1'b0;
        int n = 0, no_tick = 0, lines = 0, first_ls = 0;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            if (b_fs) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_b_frame: got no frame_start expected one within 7000 clks");
        end
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            n++;
            if (!b_tick) no_tick++;
            if (b_ls) begin
                lines++;
                if (first_ls == 0) first_ls = n;
            end
            if (b_fs) break;
        end
        n_checks++;
        if (n != 6400) begin
            n_fail++;
            $display("FAIL div1_frame: got %0d clks expected 6400", n);
        end
        n_checks++;
        if (no_tick != 0) begin
            n_fail++;
            $display("FAIL div1_tick: got %0d idle clks expected 0", no_tick);
        end
        n_checks++;
        if (first_ls != 800 || lines != 8) begin
            n_fail++;
            $display("FAIL div1_line: got period=%0d lines=%0d expected 800 and 8", first_ls, lines);
        end
    endtask

    initial begin
        test_reset();
        test_active_edge();
        test_line_wrap();
        test_vertical();
        test_async_reset();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
